// File: rtl/cpu_pkg.sv
// Shared encodings for the register-file sequencer: opcodes, instruction
// field positions, PSR bit indices and the sequencer state enum.
package cpu_pkg;

  localparam logic [3:0] OP_REG = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1101;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int EXT_LSB = 4;
  localparam int RS_LSB  = 0;
  localparam int IMM_W   = 8;

  // psr / alu_flags layout is {C,L,F,Z,N}
  localparam int PSR_N = 0;
  localparam int PSR_Z = 1;
  localparam int PSR_F = 2;
  localparam int PSR_L = 3;
  localparam int PSR_C = 4;
  localparam int PSR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  endfunction

  function automatic logic op_signed_imm(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_CMP, OP_MOV: op_signed_imm = 1'b1;
      default: op_signed_imm = 1'b0;
    endcase
  endfunction

  function automatic logic op_updates_psr(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_CMP: op_updates_psr = 1'b1;
      default: op_updates_psr = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: field extraction, legality check and
// immediate extension for one instruction word.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int SIZE    = 16,
  parameter int REGBITS = 4
) (
  input  logic [SIZE-1:0]    instr,
  output logic [3:0]         alu_op,
  output logic [REGBITS-1:0] rdest,
  output logic [REGBITS-1:0] rsrc,
  output logic [SIZE-1:0]    imm,
  output logic               is_imm,
  output logic               legal,
  output logic               writes_rf,
  output logic               updates_psr,
  output logic               is_mov
);

  logic [3:0] opcode_s;

  // Classify format, pick the ALU code and extend the 8-bit immediate
  always_comb begin
    opcode_s = instr[OPC_LSB +: 4];
    is_imm   = (opcode_s != OP_REG);
    if (is_imm) begin
      alu_op = opcode_s;
    end else begin
      alu_op = instr[EXT_LSB +: 4];
    end
    rdest = instr[RD_LSB +: REGBITS];
    rsrc  = instr[RS_LSB +: REGBITS];
    if (op_signed_imm(alu_op)) begin
      imm = {{(SIZE-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    end else begin
      imm = {{(SIZE-IMM_W){1'b0}}, instr[IMM_W-1:0]};
    end
    legal       = op_supported(alu_op);
    writes_rf   = legal && (alu_op != OP_CMP);
    updates_psr = legal && op_updates_psr(alu_op);
    is_mov      = (alu_op == OP_MOV);
  end

endmodule

// File: rtl/rf_sequencer.sv
// Five-state instruction sequencer driving an external register file and ALU:
// IDLE -> DECODE -> READ -> EXEC -> WB, all outputs registered.
module rf_sequencer
  import cpu_pkg::*;
#(
  parameter int SIZE    = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [SIZE-1:0]    instr,
  output logic [REGBITS-1:0] rf_srcAddr,
  output logic [REGBITS-1:0] rf_dstAddr,
  input  logic [SIZE-1:0]    rf_readData1,
  input  logic [SIZE-1:0]    rf_readData2,
  output logic               rf_writeEn,
  output logic [SIZE-1:0]    rf_writeData,
  output logic [SIZE-1:0]    alu_a,
  output logic [SIZE-1:0]    alu_b,
  output logic [3:0]         alu_op,
  input  logic [SIZE-1:0]    alu_result,
  input  logic [4:0]         alu_flags,
  output logic [4:0]         psr,
  output logic               done,
  output logic               illegal
);

  state_e state_r, next_s;
  logic accept_s;
  logic [SIZE-1:0] ir_r, ir_next_s;

  logic [3:0]         dec_alu_op_s;
  logic [REGBITS-1:0] dec_rdest_s, dec_rsrc_s;
  logic [SIZE-1:0]    dec_imm_s;
  logic dec_is_imm_s, dec_legal_s, dec_writes_s, dec_upd_psr_s, dec_is_mov_s;

  logic               ready_r, done_r, illegal_r, we_r;
  logic [REGBITS-1:0] src_r, dst_r;
  logic [SIZE-1:0]    alu_a_r, alu_b_r, result_r;
  logic [3:0]         alu_op_r;
  logic [4:0]         flags_r, psr_r;

  assign accept_s = (state_r == ST_IDLE) && instr_valid;

  // Decoding the word IR is about to hold lets illegal be registered into DECODE
  always_comb begin
    if (accept_s) begin
      ir_next_s = instr;
    end else begin
      ir_next_s = ir_r;
    end
  end

  instr_decode #(.SIZE(SIZE), .REGBITS(REGBITS)) u_decode (
    .instr       (ir_next_s),
    .alu_op      (dec_alu_op_s),
    .rdest       (dec_rdest_s),
    .rsrc        (dec_rsrc_s),
    .imm         (dec_imm_s),
    .is_imm      (dec_is_imm_s),
    .legal       (dec_legal_s),
    .writes_rf   (dec_writes_s),
    .updates_psr (dec_upd_psr_s),
    .is_mov      (dec_is_mov_s)
  );

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_s = ST_DECODE;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (dec_legal_s) begin
          next_s = ST_READ;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_READ: next_s = ST_EXEC;
      ST_EXEC: next_s = ST_WB;
      ST_WB:   next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State, IR and every output register; outputs are loaded for the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ir_r      <= '0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      we_r      <= 1'b0;
      src_r     <= '0;
      dst_r     <= '0;
      alu_a_r   <= '0;
      alu_b_r   <= '0;
      alu_op_r  <= 4'b0000;
      result_r  <= '0;
      flags_r   <= 5'b00000;
      psr_r     <= 5'b00000;
    end else begin
      state_r   <= next_s;
      ir_r      <= ir_next_s;
      ready_r   <= (next_s == ST_IDLE);
      done_r    <= (next_s == ST_WB);
      illegal_r <= accept_s && !dec_legal_s;
      we_r      <= (next_s == ST_WB) && dec_writes_s;
      if (next_s == ST_READ) begin
        dst_r <= dec_rdest_s;
        src_r <= dec_rsrc_s;
      end
      if (next_s == ST_EXEC) begin
        alu_op_r <= dec_alu_op_s;
        alu_a_r  <= rf_readData1;
        alu_b_r  <= dec_is_imm_s ? dec_imm_s : rf_readData2;
      end else begin
        alu_op_r <= 4'b0000;
        alu_a_r  <= '0;
        alu_b_r  <= '0;
      end
      if (state_r == ST_EXEC) begin
        result_r <= dec_is_mov_s ? alu_b_r : alu_result;
        flags_r  <= alu_flags;
      end
      if ((state_r == ST_WB) && dec_upd_psr_s) begin
        psr_r <= flags_r;
      end
    end
  end

  assign instr_ready  = ready_r;
  assign done         = done_r;
  assign illegal      = illegal_r;
  assign rf_writeEn   = we_r;
  assign rf_writeData = result_r;
  assign rf_srcAddr   = src_r;
  assign rf_dstAddr   = dst_r;
  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_op       = alu_op_r;
  assign psr          = psr_r;

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer with a behavioural register file and ALU;
// expected write-backs go through a scoreboard queue.
module tb_rf_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic [3:0]  rf_srcAddr, rf_dstAddr;
  logic [15:0] rf_readData1, rf_readData2;
  logic        rf_writeEn;
  logic [15:0] rf_writeData;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done, illegal;

  rf_sequencer #(.SIZE(16), .REGBITS(4)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_srcAddr(rf_srcAddr), .rf_dstAddr(rf_dstAddr),
    .rf_readData1(rf_readData1), .rf_readData2(rf_readData2),
    .rf_writeEn(rf_writeEn), .rf_writeData(rf_writeData),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .psr(psr), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] regs [16] = '{16'h0000, 16'hFFFF, 16'h0005, 16'h0007,
                             16'h1234, 16'h0009, 16'h0000, 16'h1111,
                             16'h00F0, 16'h0A0A, 16'h0000, 16'hBEEF,
                             16'h5555, 16'h0000, 16'h0000, 16'h0000};

  assign rf_readData1 = regs[rf_dstAddr];
  assign rf_readData2 = regs[rf_srcAddr];

  always @(posedge clk) begin
    if (rf_writeEn === 1'b1) regs[rf_dstAddr] <= rf_writeData;
  end

  // Reference ALU; returns {C,L,F,Z,N, result}. MOV yields junk so its
  // write-back must come from alu_b.
  function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic c, f;
    s = 17'h00000; c = 1'b0; f = 1'b0;
    case (op)
      4'h1: r = a & b;
      4'h2: r = a | b;
      4'h3: r = a ^ b;
      4'h5: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                  f = (a[15] == b[15]) && (r[15] != a[15]); end
      4'h9, 4'hB: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
                  f = (a[15] != b[15]) && (r[15] != a[15]); end
      default: r = 16'hDEAD;
    endcase
    alu_fn = {c, (a < b), f, (r == 16'h0000), r[15], r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_op, alu_a, alu_b);

  typedef struct packed { logic [3:0] addr; logic [15:0] data; } wr_t;
  wr_t sb[$];
  int total = 0;
  int bad = 0;
  logic [4:0] psr_exp = 5'b00000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_write();
    wr_t w;
    if (rf_writeEn === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL spurious_write: observed addr=%0h data=%0h expected no write", rf_dstAddr, rf_writeData);
      end
      if (sb.size() > 0) begin
        w = sb.pop_front();
        chk("wb_addr", rf_dstAddr, w.addr);
        chk("wb_data", rf_writeData, w.data);
      end
    end
  endtask

  task automatic issue(input logic [15:0] w);
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    chk("ready_at_offer", instr_ready, 1'b1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'h0000;
  endtask

  task automatic run(input logic [15:0] w);
    logic [3:0] op;
    logic [15:0] a, b, imm, res;
    logic [4:0] fl;
    logic legal, wr, upd;
    op = (w[15:12] == 4'h0) ? w[7:4] : w[15:12];
    legal = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    imm = (op inside {4'h5, 4'h9, 4'hB, 4'hD}) ? {{8{w[7]}}, w[7:0]} : {8'h00, w[7:0]};
    a = regs[w[11:8]];
    b = (w[15:12] != 4'h0) ? imm : regs[w[3:0]];
    {fl, res} = alu_fn(op, a, b);
    if (op == 4'hD) res = b;
    wr = legal && (op != 4'hB);
    upd = legal && (op inside {4'h5, 4'h9, 4'hB});
    if (wr) sb.push_back({w[11:8], res});
    issue(w);
    @(negedge clk);
    check_write();
    chk("decode_illegal", illegal, !legal);
    chk("decode_done", done, 1'b0);
    chk("decode_we", rf_writeEn, 1'b0);
    chk("decode_ready", instr_ready, 1'b0);
    if (!legal) begin
      @(negedge clk);
      check_write();
      chk("illegal_ready_next", instr_ready, 1'b1);
      chk("illegal_clears", illegal, 1'b0);
      chk("illegal_psr", psr, psr_exp);
      chk("illegal_done", done, 1'b0);
    end else begin
      @(negedge clk);
      check_write();
      chk("read_dst", rf_dstAddr, w[11:8]);
      chk("read_src", rf_srcAddr, w[3:0]);
      chk("read_aluop_zero", alu_op, 4'h0);
      @(negedge clk);
      check_write();
      chk("exec_aluop", alu_op, op);
      chk("exec_a", alu_a, a);
      chk("exec_b", alu_b, b);
      chk("exec_we", rf_writeEn, 1'b0);
      @(negedge clk);
      chk("wb_we", rf_writeEn, wr);
      check_write();
      chk("wb_done", done, 1'b1);
      chk("wb_alu_b_zero", alu_b, 16'h0000);
      if (upd) psr_exp = fl;
      @(negedge clk);
      check_write();
      chk("after_psr", psr, psr_exp);
      chk("after_ready", instr_ready, 1'b1);
      chk("after_done", done, 1'b0);
      chk("sb_drained", sb.size(), 0);
    end
  endtask

  initial begin
    int acc;
    logic [15:0] saved;
    logic [15:0] table_words [7] = '{16'h9002, 16'h0738, 16'h290F, 16'h0ADB,
                                     16'h0A0B, 16'hF000, 16'h3C80};
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psr", psr, 5'b00000);
    chk("rst_done", done, 1'b0);
    chk("rst_we", rf_writeEn, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_aluop", alu_op, 4'h0);
    chk("rst_dst", rf_dstAddr, 4'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", instr_ready, 1'b1);

    run(16'h0355);
    chk("add_r3", regs[3], 16'h0010);
    run(16'h52FF);
    chk("addi_r2", regs[2], 16'h0004);
    chk("addi_psr", psr, 5'b11000);
    run(16'h1180);
    chk("andi_r1", regs[1], 16'h0080);
    chk("andi_psr_kept", psr, 5'b11000);
    run(16'h04B4);
    chk("cmp_z", psr[1], 1'b1);
    chk("cmp_r4_kept", regs[4], 16'h1234);
    run(16'h7123);
    chk("illegal_psr_kept", psr, 5'b00010);
    for (int i = 0; i < 7; i++) run(table_words[i]);
    chk("subi_r0", regs[0], 16'hFFFE);
    chk("mov_r10", regs[10], 16'hBEEF);

    // instr_valid held high: one acceptance per five cycles
    @(negedge clk);
    instr = 16'hD603;
    instr_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      check_write();
      if (instr_ready === 1'b1) begin
        acc++;
        sb.push_back({4'h6, 16'h0003});
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("held_acceptances", acc, 2);
    repeat (6) begin
      @(negedge clk);
      check_write();
    end
    chk("held_sb_drained", sb.size(), 0);
    chk("movi_r6", regs[6], 16'h0003);
    chk("movi_psr_kept", psr, psr_exp);

    // Reset during EXEC of ADD R3,R5
    saved = regs[3];
    issue(16'h0355);
    repeat (3) @(negedge clk);
    chk("pre_reset_exec", alu_op, 4'h5);
    reset = 1'b1;
    @(negedge clk);
    chk("rstx_we", rf_writeEn, 1'b0);
    chk("rstx_done", done, 1'b0);
    chk("rstx_psr", psr, 5'b00000);
    chk("rstx_ready", instr_ready, 1'b1);
    chk("rstx_aluop", alu_op, 4'h0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_we", rf_writeEn, 1'b0);
      chk("post_rst_done", done, 1'b0);
      chk("post_rst_ready", instr_ready, 1'b1);
    end
    chk("rstx_r3_kept", regs[3], saved);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
